hazard_stall_ctrl: RTL
======================

# hazard_stall_ctrl

Stall/flush controller for the five-stage pipeline. It decides each cycle whether the F/D stage must hold and a bubble must be injected into the D/E register. It combines register-dependency (Tuse/Tnew) hazard detection with a countdown that tracks the multi-cycle multiply/divide unit. It drives the PC write enable, the F/D register write enable and the D/E register flush input, and keeps a free-running stall-cycle statistic.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles loaded for mult/multu
- DIV_CYCLES, 10, busy cycles loaded for div/divu
- CNT_W, 4, width of the busy counter; must hold max(MULT_CYCLES, DIV_CYCLES)

Ports:
- clk  input  1  pipeline clock, rising edge
- reset  input  1  asynchronous, active-high reset
- D_rs_addr  input  5  rs field of the instruction in D
- D_rt_addr  input  5  rt field of the instruction in D
- D_Tuse_rs  input  2  cycles until D needs rs; 3 = not used
- D_Tuse_rt  input  2  cycles until D needs rt; 3 = not used
- D_is_md  input  1  D instruction uses the HI/LO unit (mult/div/mfhi/mflo/mthi/mtlo)
- E_dst  input  5  destination register of the E instruction; 0 = none
- E_Tnew  input  2  cycles until the E result is forwardable
- M_dst  input  5  destination register of the M instruction; 0 = none
- M_Tnew  input  2  cycles until the M result is forwardable
- E_md_start  input  1  a mult/div is in E this cycle (start pulse)
- E_md_is_div  input  1  qualifies E_md_start: 1 = div, 0 = mult
- PC_WrEn  output  1  PC update enable
- FD_WrEn  output  1  F/D register write enable
- DE_flush  output  1  D/E register flush (bubble insert)
- md_busy  output  1  HI/LO unit busy
- md_count  output  CNT_W  remaining busy cycles
- stall_cycles  output  32  count of cycles with stall asserted

## Operation
- stall_rs = D_rs_addr!=0 && ((D_rs_addr==E_dst && D_Tuse_rs<E_Tnew) || (D_rs_addr==M_dst && D_Tuse_rs<M_Tnew)).
- stall_rt is the same expression using rt.
- md_busy = E_md_start || md_count!=0.
- stall_md = D_is_md && md_busy.
- stall = stall_rs || stall_rt || stall_md.
- Outputs are combinational from stall:
  - PC_WrEn = FD_WrEn = ~stall
  - DE_flush = stall
- Busy counter, evaluated at each rising edge:
  - E_md_start=1: load DIV_CYCLES if E_md_is_div, else MULT_CYCLES.
  - Otherwise, if md_count!=0: decrement.
  - Otherwise: hold at 0.
- E_md_start while md_count!=0 cannot occur in correct operation because stall_md blocks it. If it does occur, the reload wins.
- stall_cycles increments by 1 at each edge where stall=1. It wraps from 0xFFFFFFFF to 0.
- Register 0 never causes a hazard, even if E_dst or M_dst is 0.
- Tuse=3 never satisfies Tuse<Tnew, because Tnew is at most 2.

## Timing
- Asynchronous reset while reset=1:
  - md_count=0, stall_cycles=0, md_busy=0
  - PC_WrEn=1, FD_WrEn=1, DE_flush=0 (outputs are forced, independent of the other inputs)
- After reset deasserts, normal evaluation starts in the same cycle. Reset asserted mid-countdown clears md_count immediately.
- Hazard stalls have zero latency: stall is asserted in the same cycle the inputs present the hazard.
- Stall cycles for an MD-dependent instruction after a mult:
  - Cycle of start: 1 (E_md_start=1).
  - Then MULT_CYCLES more cycles: md_count=5,4,3,2,1.
  - Total 6 stall cycles. D advances in the cycle md_count==0.
  - div gives 11 stall cycles.
- Simultaneous data hazard and md hazard: a single stall. stall_cycles still increments only by 1 per cycle.
- Simultaneous E and M match on the same register: stall if either condition holds.

## Test plan
- Load-use: E_dst=8, E_Tnew=2, D_rs_addr=8, D_Tuse_rs=1 -> stall=1, DE_flush=1, PC_WrEn=0. Next cycle with M_dst=8, M_Tnew=1, no E match -> stall=0.
- $0 guard: E_dst=0, E_Tnew=2, D_rs_addr=0, D_Tuse_rs=0 -> no stall.
- mult then mfhi: E_md_start=1, E_md_is_div=0, D_is_md=1 held -> stall for exactly 6 cycles. md_count sequence is 5,4,3,2,1,0. stall_cycles=6.
- div with an unrelated D instruction (D_is_md=0): no stall, md_busy=1 for 11 cycles. Then D_is_md=1 at md_count=3 -> stall for 3 cycles.
- Reset pulsed asynchronously at md_count=7 -> md_count=0, md_busy=0, stall_cycles=0 and PC_WrEn=1 before the next clock edge.
- stall_cycles preloaded near wrap: drive 2 stall cycles from 0xFFFFFFFF -> counter reads 0, then 1.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// Pipeline stall/flush controller: Tuse/Tnew register hazards plus a countdown
// that covers the multi-cycle mult/div unit, with a free-running stall counter.
module hazard_stall_ctrl #(
   parameter int unsigned MULT_CYCLES    = 5,
   parameter int unsigned DIV_CYCLES     = 10,
   parameter int unsigned CNT_W          = 4,
   parameter logic [31:0] STALL_CNT_INIT = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       D_rs_addr,
   input  logic [4:0]       D_rt_addr,
   input  logic [1:0]       D_Tuse_rs,
   input  logic [1:0]       D_Tuse_rt,
   input  logic             D_is_md,
   input  logic [4:0]       E_dst,
   input  logic [1:0]       E_Tnew,
   input  logic [4:0]       M_dst,
   input  logic [1:0]       M_Tnew,
   input  logic             E_md_start,
   input  logic             E_md_is_div,
   output logic             PC_WrEn,
   output logic             FD_WrEn,
   output logic             DE_flush,
   output logic             md_busy,
   output logic [CNT_W-1:0] md_count,
   output logic [31:0]      stall_cycles
);

   logic stall_rs;
   logic stall_rt;
   logic stall_md;
   logic stall;

   // $0 never hazards; Tuse=3 can never be below a 2-bit Tnew of at most 2
   always_comb begin
      stall_rs = (D_rs_addr != 5'd0) &&
                 (((D_rs_addr == E_dst) && (D_Tuse_rs < E_Tnew)) ||
                  ((D_rs_addr == M_dst) && (D_Tuse_rs < M_Tnew)));
      stall_rt = (D_rt_addr != 5'd0) &&
                 (((D_rt_addr == E_dst) && (D_Tuse_rt < E_Tnew)) ||
                  ((D_rt_addr == M_dst) && (D_Tuse_rt < M_Tnew)));
   end

   // Reset forces the pipeline-facing outputs to their idle values
   always_comb begin
      md_busy  = !reset && (E_md_start || (md_count != '0));
      stall_md = D_is_md && md_busy;
      stall    = !reset && (stall_rs || stall_rt || stall_md);
      PC_WrEn  = !stall;
      FD_WrEn  = !stall;
      DE_flush = stall;
   end

   // A start pulse reloads even if a countdown is still running
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         md_count <= '0;
      end else if (E_md_start) begin
         md_count <= E_md_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
      end else if (md_count != '0) begin
         md_count <= md_count - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cycles <= STALL_CNT_INIT;
      end else if (stall) begin
         stall_cycles <= stall_cycles + 32'd1;
      end
   end

endmodule
